div32_seq: RTL
==============

// Module: div32_seq
// PURPOSE
//  Iterative restoring divider implementing RV32M DIV/DIVU/REM/REMU: the subtract-based
//  inverse of the ripple adder path. Sits beside the ALU in EX; the core raises start,
//  stalls on busy, and captures result on the done pulse. One quotient bit per cycle.
// PARAMETERS
//  WIDTH    32   operand/result width (even, >=4)
//  CNT_W    6    iteration counter width (must hold WIDTH; clog2(WIDTH)+1)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      request; sampled only in IDLE
//  op           in   2      [0]=1 remainder (REM*), [1]=1 unsigned (DIVU/REMU)
//  a            in   WIDTH  dividend, sampled with start
//  b            in   WIDTH  divisor, sampled with start
//  busy         out  1      1 from the cycle after accept through the done cycle
//  done         out  1      one-cycle pulse; result valid in this cycle
//  result       out  WIDTH  quotient or remainder; held until next accept
//  div_by_zero  out  1      set with done when b==0; held like result
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=0, done=0, result=0, div_by_zero=0, counter=0.
//  - States: IDLE -> CALC -> FINISH -> IDLE.
//  - IDLE: start=1 at edge T latches op, |a|, |b| (abs only if signed), quotient sign
//    (a[MSB]^b[MSB]), remainder sign (a[MSB]); partial remainder cleared; counter=WIDTH-1;
//    go CALC. start=0: stay.
//  - CALC (WIDTH cycles, T+1..T+WIDTH): shift {rem,dvd} left 1; trial = rem - divisor (WIDTH+1 bits);
//    trial >= 0 -> rem=trial, q bit=1, else restore, q bit=0. counter==0 -> FINISH, else decrement.
//  - FINISH (cycle T+WIDTH+1): apply sign correction (2's complement negate), select
//    quotient/remainder by op[0], drive result, done=1, busy=1; next edge -> IDLE.
//  - Latency: done exactly WIDTH+1 cycles after accepting edge (33 at default). Back-to-back:
//    start may be high in the cycle after done; no overlap.
//  - start while busy: ignored, no effect on operands or timing.
//  - Special cases (RISC-V spec, no traps):
//    b==0: quotient = all ones, remainder = a (original, unsigned reinterpretation irrelevant);
//    div_by_zero=1. Signed a==MIN_INT, b==-1: quotient=MIN_INT, remainder=0.
//    Special results override the datapath at FINISH; latency unchanged unless macro set.
//  - Widths: abs and negate at WIDTH bits (MIN_INT abs = MIN_INT, treated unsigned);
//    trial subtract one extra bit for borrow.
//  - done, div_by_zero never assert in IDLE except result/div_by_zero holding previous values.
// CONFIGURATION
//  - DIV_EARLY_OUT_EN defined: b==0 or signed-overflow detected at accept skips CALC;
//    IDLE -> FINISH, done at T+1. All other operands keep full WIDTH+1 latency.
//  - Not defined: every operation takes WIDTH+1 cycles, special cases fixed up at FINISH.
// TESTING
//  1. DIVU a=100, b=7 at T -> done at T+33, result=14, div_by_zero=0; REMU same -> 2.
//  2. DIV a=-100 (0xFFFFFF9C), b=7 -> result=0xFFFFFFF2 (-14); REM -> 0xFFFFFFFE (-2).
//  3. DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000; REM -> 0; no div_by_zero.
//  4. DIVU a=0x1234, b=0 -> result=0xFFFFFFFF, div_by_zero=1; REMU -> 0x1234;
//     done at T+33 without macro, T+1 with DIV_EARLY_OUT_EN.
//  5. start pulsed again at T+5 with new operands -> ignored; first result unchanged at T+33;
//     start at T+34 accepted, done at T+67.
//  6. rst asserted at T+10 mid-CALC -> busy/done/result 0 immediately; new start after
//     release completes normally with full latency.

Source files
------------

// File: rtl/div32_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration phase.
`timescale 1ns/1ps

module div32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start is accepted only in IDLE. busy stays high from the cycle after
  // accept through the done cycle. done is a one-cycle pulse with result/div_by_zero
  // valid, and both stay held afterwards until the next operation completes.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       op_q, op_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             bz_q, bz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             b_zero, ovf_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic [WIDTH-1:0] fin_res;

  // Operand conditioning at accept; MIN_INT stays MIN_INT and is then read as unsigned.
  assign a_neg  = ~op[1] & a[WIDTH-1];
  assign b_neg  = ~op[1] & b[WIDTH-1];
  assign a_abs  = a_neg ? (ZERO - a) : a;
  assign b_abs  = b_neg ? (ZERO - b) : b;
  assign b_zero = (b == ZERO);
  assign ovf_in = ~op[1] & (a == MIN_INT) & (b == ALL_ONES);

  // One restoring step; the top bit of trial is the borrow.
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dsr_q};
  assign q_bit    = ~trial[WIDTH+1];
  assign rem_next = q_bit ? WIDTH'(trial) : shifted[WIDTH-1:0];

  always_comb begin
    quot_fix = negq_q ? (ZERO - dvd_q) : dvd_q;
    rem_fix  = negr_q ? (ZERO - rem_q) : rem_q;
    if (bz_q) begin
      quot_fix = ALL_ONES;
      rem_fix  = a_q;
    end else if (ovf_q) begin
      quot_fix = MIN_INT;
      rem_fix  = ZERO;
    end
    fin_res = op_q[0] ? rem_fix : quot_fix;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    a_d      = a_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    bz_d     = bz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          dvd_d   = a_abs;
          dsr_d   = b_abs;
          rem_d   = ZERO;
          negq_d  = ~op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d  = a_neg;
          bz_d    = b_zero;
          ovf_d   = ovf_in;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
          if (b_zero || ovf_in) begin
            state_d = S_FINISH;
          end
`else
`endif
        end
      end
      S_CALC: begin
        rem_d = rem_next;
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        if (cnt_q == '0) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FINISH: begin
        result_d = fin_res;
        dbz_d    = bz_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      a_q      <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      bz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      a_q      <= a_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      bz_q     <= bz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // The finished value is visible combinationally in the done cycle and registered on exit.
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign result      = done ? fin_res : result_q;
  assign div_by_zero = done ? bz_q : dbz_q;
  assign dbg_state_o = state_q;

endmodule
